// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encodings shared with the ALU control decoder, plus execute-stage FSM states.
package alu_pkg;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
endpackage

// File: rtl/alu_exec_mul_iter.sv
// mul_iter: iterative shift-add unsigned multiplier, one partial product per clock, WIDTH iterations.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH:0]     w_sum;
  // multiplier sits in the low half and is consumed one bit per shift
  assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_mcand <= i_a;
        r_prod  <= {{WIDTH{1'b0}}, i_b};
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
        r_cnt  <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_prod = r_prod;
endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with start/ready/done handshake and registered result/zero.
// Define MULT_EN to add the iterative MULTU operation (code 1000) and the MUL state.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero
);
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_done;
  logic [WIDTH-1:0] w_res;
  logic             w_accept;
  logic             w_to_mul;
  assign w_accept = start && r_state == IDLE;
  always_comb begin
    w_res = r_op == ALU_AND ? r_a & r_b :
            r_op == ALU_OR  ? r_a | r_b :
            r_op == ALU_ADD ? r_a + r_b :
            r_op == ALU_SUB ? r_a - r_b :
            r_op == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(r_a) < $signed(r_b)} :
            r_op == ALU_NOR ? ~(r_a | r_b) : '0;
  end
`ifdef MULT_EN
  logic               w_mul_busy;
  logic               w_mul_done;
  logic               w_mul_load;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   r_hi;
  assign w_mul_load = w_accept && alu_ctrl == ALU_MULTU && !w_mul_busy;
  assign w_to_mul   = w_mul_load;
  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_mul_load),
    .i_a    (src_a),
    .i_b    (src_b),
    .o_busy (w_mul_busy),
    .o_done (w_mul_done),
    .o_prod (w_prod)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hi <= '0;
    else if (r_state == EXEC) r_hi <= '0;
    else if (r_state == MUL && w_mul_done) r_hi <= w_prod[2*WIDTH-1:WIDTH];
  end
  assign result_hi = r_hi;
`else
  assign w_to_mul  = 1'b0;
  assign result_hi = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= ALU_AND;
      r_res   <= '0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_a     <= src_a;
          r_b     <= src_b;
          r_op    <= alu_ctrl;
          r_state <= w_to_mul ? MUL : EXEC;
        end
        EXEC: begin
          r_res   <= w_res;
          r_zero  <= w_res == '0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
`ifdef MULT_EN
        MUL: if (w_mul_done) begin
          r_res   <= w_prod[WIDTH-1:0];
          r_zero  <= w_prod[WIDTH-1:0] == '0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ready  = r_state == IDLE;
  assign done   = r_done;
  assign result = r_res;
  assign zero   = r_zero;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec; MULT_EN selects the multiplier vectors.
module tb_alu_exec;
  import alu_pkg::*;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alu_ctrl = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         ready;
  logic         done;
  logic         zero;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    int           due;
    string        nm;
  } exp_t;
  exp_t q[$];
  exp_t e;
  alu_exec #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk({e.nm, "_result"}, result, e.res);
        chk({e.nm, "_result_hi"}, result_hi, e.hi);
        chk({e.nm, "_zero"}, W'(zero), W'(e.z));
        chk({e.nm, "_latency"}, W'(cyc), W'(e.due));
        chk({e.nm, "_ready_in_done"}, W'(ready), W'(1'b1));
      end
    end
  end
  task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic push, input logic exp_rdy,
                       input int lat, input logic [W-1:0] res, input logic [W-1:0] hi,
                       input logic z);
    @(negedge clk);
    alu_ctrl = op;
    src_a = a;
    src_b = b;
    start = 1'b1;
    chk({nm, "_ready_at_start"}, W'(ready), W'(exp_rdy));
    @(posedge clk);
    #1;
    start = 1'b0;
    src_a = ~a;
    src_b = ~b;
    alu_ctrl = ~op;
    if (push) q.push_back('{res: res, hi: hi, z: z, due: cyc + lat, nm: nm});
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending ops expected 0", q.size());
      q.delete();
    end
  endtask
  initial begin
    int m;
    repeat (2) @(negedge clk);
    chk("rst_ready", W'(ready), W'(1'b1));
    chk("rst_done", W'(done), W'(1'b0));
    chk("rst_result", result, '0);
    chk("rst_result_hi", result_hi, '0);
    chk("rst_zero", W'(zero), W'(1'b1));
    rst_n = 1'b1;
    issue("add", ALU_ADD, 32'd7, 32'd5, 1, 1, 1, 32'd12, '0, 1'b0); drain();
    issue("sub", ALU_SUB, 32'd5, 32'd5, 1, 1, 1, 32'd0, '0, 1'b1); drain();
    issue("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1, 1, 1, 32'd0, '0, 1'b1); drain();
    issue("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1, 1, 1, 32'd1, '0, 1'b0); drain();
    issue("slt_false", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 1, 1, 1, 32'd0, '0, 1'b1); drain();
    issue("nor", ALU_NOR, 32'd0, 32'd0, 1, 1, 1, 32'hFFFF_FFFF, '0, 1'b0); drain();
    issue("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 1, 1, 1, 32'h0000_F000, '0, 1'b0); drain();
    issue("or", ALU_OR, 32'h0000_F0F0, 32'h0000_FF00, 1, 1, 1, 32'h0000_FFF0, '0, 1'b0); drain();
    issue("unknown", 4'b1111, 32'd3, 32'd4, 1, 1, 1, 32'd0, '0, 1'b1); drain();
`ifdef MULT_EN
    issue("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 1, 1, W + 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    m = cyc;
    repeat (3) @(posedge clk);
    issue("mid_mul_add", ALU_ADD, 32'd1, 32'd1, 0, 0, 1, '0, '0, 1'b0);
    while (cyc < m + W + 1) begin
      @(posedge clk);
      #1;
    end
    issue("b2b_add", ALU_ADD, 32'd7, 32'd5, 1, 1, 1, 32'd12, '0, 1'b0);
    drain();
`else
    issue("op1000", 4'b1000, 32'd3, 32'd4, 1, 1, 1, 32'd0, '0, 1'b1); drain();
    m = 0;
`endif
    issue("pre_rst_add", ALU_ADD, 32'd7, 32'd5, 1, 1, 1, 32'd12, '0, 1'b0); drain();
`ifdef MULT_EN
    issue("rst_multu", ALU_MULTU, 32'hFFFF_FFFF, 32'd3, 0, 1, 0, '0, '0, 1'b0);
`endif
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", W'(ready), W'(1'b1));
    chk("async_rst_done", W'(done), W'(1'b0));
    chk("async_rst_result", result, '0);
    chk("async_rst_result_hi", result_hi, '0);
    chk("async_rst_zero", W'(zero), W'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 8) @(posedge clk);
    #1;
    chk("post_rst_ready", W'(ready), W'(1'b1));
    chk("post_rst_result", result, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
